muldiv_sequencer: RTL and testbench

- Iterative multiply/divide controller for the EX stage of the 5-stage MIPS pipeline; owns the HI/LO registers.
- Accepts mult/div requests decoded alongside the ALU control path.
- Runs a 32-step shift-add (mult) or restoring shift-subtract (div) sequence.
- Drives a stall to the hazard logic while busy.
- Also services mfhi/mflo reads and mthi/mtlo writes.

---
 rtl/muldiv_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning HI/LO for the EX stage.
// Define MULDIV_SIGNED_EN to give op 10/11 signed semantics.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] acc, sr, dvs;
    logic [CNT_W-1:0] cnt;
    logic             is_div, dz;
    logic             accept, last, start_dz;
    logic [WIDTH-1:0] a_in, b_in;
    logic [WIDTH:0]   sum, trial;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] acc_nx, sr_nx;
    logic [WIDTH-1:0] res_hi, res_lo;

`ifdef MULDIV_SIGNED_EN
    logic neg_hi, neg_lo;
    logic sgn_a, sgn_b;
    assign sgn_a = op[1] & src_a[WIDTH-1];
    assign sgn_b = op[1] & src_b[WIDTH-1];
`else
    logic unused_op;
    assign unused_op = op[1];
`endif

    assign accept   = (state == IDLE) && start && !flush;
    assign start_dz = op[0] && (src_b == '0);
    assign last     = (cnt == CNT_W'(WIDTH - 1));
    assign busy     = (state != IDLE);
    // Held while busy so refused starts and mthi/mtlo are retried.
    assign stall    = busy || ((start || hi_we || lo_we) && state != IDLE);

    always_comb begin
        a_in = src_a;
        b_in = src_b;
`ifdef MULDIV_SIGNED_EN
        if (sgn_a) a_in = -src_a;
        if (sgn_b) b_in = -src_b;
`endif
    end

    // Mult: {acc,sr} is product/multiplier; div: acc remainder, sr quotient.
    always_comb begin
        sum   = {1'b0, acc} + (sr[0] ? {1'b0, dvs} : '0);
        trial = {acc, sr[WIDTH-1]};
        ge    = (trial >= {1'b0, dvs});
        diff  = trial[WIDTH-1:0] - dvs;
        if (is_div) begin
            acc_nx = ge ? diff : trial[WIDTH-1:0];
            sr_nx  = {sr[WIDTH-2:0], ge};
        end else begin
            acc_nx = sum[WIDTH:1];
            sr_nx  = {sum[0], sr[WIDTH-1:1]};
        end
    end

    always_comb begin
        res_hi = acc;
        res_lo = sr;
        if (dz) begin
            res_hi = sr;
            res_lo = '1;
        end
`ifdef MULDIV_SIGNED_EN
        else if (is_div) begin
            if (neg_lo) res_lo = -sr;
            if (neg_hi) res_hi = -acc;
        end else if (neg_lo) begin
            {res_hi, res_lo} = -{acc, sr};
        end
`endif
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = start_dz ? FINISH : RUN;
            end
            RUN: begin
                if (flush)     state_nx = IDLE;
                else if (last) state_nx = FINISH;
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            sr       <= '0;
            dvs      <= '0;
            is_div   <= 1'b0;
            dz       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (accept) begin
                        is_div   <= op[0];
                        dz       <= start_dz;
                        div_zero <= 1'b0;
                        cnt      <= '0;
                        acc      <= '0;
                        if (start_dz) begin
                            sr  <= src_a;
                            dvs <= '0;
                        end else if (op[0]) begin
                            sr  <= a_in;
                            dvs <= b_in;
                        end else begin
                            sr  <= b_in;
                            dvs <= a_in;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_nx;
                    sr  <= sr_nx;
                    cnt <= cnt + 1'b1;
                end
                FINISH: begin
                    if (!flush) begin
                        hi       <= res_hi;
                        lo       <= res_lo;
                        div_zero <= dz;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MULDIV_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_hi <= 1'b0;
            neg_lo <= 1'b0;
        end else if (accept) begin
            neg_lo <= sgn_a ^ sgn_b;
            neg_hi <= sgn_a;
        end
    end
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed vectors, monitor
// compares HI/LO/div_zero and completion cycle on every done pulse.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        flush, hi_we, lo_we;
    logic [31:0] wdata;
    logic [31:0] hi, lo;
    logic        busy, stall, done, div_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall),
        .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            pass_cnt++;
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                check("done_without_request", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("hi", 64'(hi), 64'(e.hi));
                check("lo", 64'(lo), 64'(e.lo));
                check("div_zero", 64'(div_zero), 64'(e.dz));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit push,
                         input logic [31:0] eh, input logic [31:0] el,
                         input logic edz, input int lat);
        exp_t e;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        if (push) begin
            e.hi  = eh;
            e.lo  = el;
            e.dz  = edz;
            e.cyc = cyc + lat;
            sb_q.push_back(e);
        end
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("wait_idle", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 0; op = 0; src_a = 0; src_b = 0;
        flush = 0; hi_we = 0; lo_we = 0; wdata = 0;
        step(2);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);
        rst_n = 1'b1;
        step(1);

        // multu max x max, busy across the whole run
        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1,
              32'hFFFFFFFE, 32'h00000001, 0, 33);
        for (int k = 0; k <= 33; k++) begin
            @(negedge clk);
            check("mul_busy", 64'(busy), 64'(k < 33));
            check("mul_stall", 64'(stall), 64'(k < 33));
        end
        step(1);

        // divu 100/7 with a refused second start
        issue(2'b01, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0, 33);
        step(4);
        start = 1'b1; op = 2'b00; src_a = 32'd9; src_b = 32'd9;
        @(negedge clk);
        check("busy_start_stall", 64'(stall), 64'd1);
        step(1);
        start = 1'b0;
        wait_idle();

        issue(2'b01, 32'hDEADBEEF, 32'h10, 1,
              32'hF, 32'h0DEADBEE, 0, 33);
        wait_idle();

        // divide by zero, then a multu clears the sticky flag
        issue(2'b01, 32'd5, 32'd0, 1, 32'd5, 32'hFFFFFFFF, 1, 1);
        wait_idle();
        check("dz_sticky", 64'(div_zero), 64'd1);
        issue(2'b00, 32'd2, 32'd3, 1, 32'd0, 32'd6, 0, 33);
        @(negedge clk);
        check("dz_cleared", 64'(div_zero), 64'd0);
        wait_idle();

        // mthi preload, mtlo dropped while busy, flush aborts
        hi_we = 1'b1; wdata = 32'hAAAA0000;
        step(1);
        hi_we = 1'b0;
        check("mthi", 64'(hi), 64'hAAAA0000);
        issue(2'b00, 32'd3, 32'd4, 0, 0, 0, 0, 0);
        step(4);
        lo_we = 1'b1; wdata = 32'h00001234;
        @(negedge clk);
        check("mtlo_busy_stall", 64'(stall), 64'd1);
        step(1);
        lo_we = 1'b0;
        step(4);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(busy), 64'd0);
        step(40);
        check("flush_hi", 64'(hi), 64'hAAAA0000);
        check("flush_lo", 64'(lo), 64'd6);

        // op 10/11
`ifdef MULDIV_SIGNED_EN
        issue(2'b10, 32'hFFFFFFFD, 32'd5, 1,
              32'hFFFFFFFF, 32'hFFFFFFF1, 0, 33);
        wait_idle();
        issue(2'b11, 32'hFFFFFFF9, 32'd2, 1,
              32'hFFFFFFFF, 32'hFFFFFFFD, 0, 33);
        wait_idle();
`else
        issue(2'b10, 32'hFFFFFFFD, 32'd5, 1,
              32'h00000004, 32'hFFFFFFF1, 0, 33);
        wait_idle();
        issue(2'b11, 32'hFFFFFFF9, 32'd2, 1,
              32'h00000001, 32'h7FFFFFFC, 0, 33);
        wait_idle();
`endif

        // async reset mid-divu, then a clean run
        issue(2'b01, 32'd1000, 32'd3, 0, 0, 0, 0, 0);
        step(14);
        rst_n = 1'b0;
        #1;
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_stall", 64'(stall), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        step(1);
        rst_n = 1'b1;
        step(1);
        issue(2'b00, 32'd7, 32'd6, 1, 32'd0, 32'd42, 0, 33);
        wait_idle();
        step(2);

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
